// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/D requesters, the unified memory and the arbiter.
// Handshake: a requester raises *_req and holds it (with its addr/we/wdata) stable until
// the one-cycle *_gnt pulse; *_rvalid or *_err follows exactly one cycle after *_gnt.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares the multicycle MIPS unified memory between instruction fetch and load/store,
// with data priority and a starvation guard that forces IF through after STARVE_LIMIT losses.
module unified_mem_arbiter #(
  parameter int MEM_WORDS    = 256,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus,
  output logic                 dbg_state,
  output logic [3:0]           dbg_starve_cnt
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        pick_if, pick_d;
  logic        owner_d_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  starve_q;
  logic        if_rvalid_q, if_err_q, d_rvalid_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        in_access, addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pick_if = 1'b0;
    pick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && starve_q == LIMIT)) pick_d = 1'b1;
        else if (bus.if_req)                                 pick_if = 1'b1;
        if (pick_d || pick_if) state_d = ACCESS;
      end
      ACCESS: state_d = IDLE;
    endcase
  end

  assign in_access = (state_q == ACCESS);
  assign addr_ok   = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < 30'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;

      if (pick_d || pick_if) begin
        owner_d_q <= pick_d;
        addr_q    <= pick_d ? bus.d_addr : bus.if_addr;
        we_q      <= pick_d & bus.d_we;
        wdata_q   <= pick_d ? bus.d_wdata : 32'h0;
      end

      // Only contested D wins count against IF; uncontested D grants leave it alone.
      if (pick_if)                                            starve_q <= '0;
      else if (pick_d && bus.if_req && starve_q < LIMIT)      starve_q <= starve_q + 4'd1;

      if (in_access) begin
        if (!addr_ok) begin
          if (owner_d_q) d_err_q  <= 1'b1;
          else           if_err_q <= 1'b1;
        end else if (!we_q) begin
          if (owner_d_q) begin
            d_rvalid_q <= 1'b1;
            d_rdata_q  <= bus.mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= bus.mem_rdata;
          end
        end
      end
    end
  end

  // Strobes are decoded from registers so an async reset clears them at once.
  assign bus.if_gnt    = in_access & ~owner_d_q;
  assign bus.d_gnt     = in_access &  owner_d_q;
  assign bus.mem_read  = in_access & ~we_q & addr_ok;
  assign bus.mem_write = in_access &  we_q & addr_ok;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, hand sequences for starvation,
// back-to-back fetch and reset mid-access, then random traffic against a transaction model.
module tb_unified_mem_arbiter;
  localparam int MEM_WORDS    = 256;
  localparam int STARVE_LIMIT = 2;
  localparam int RAND_CYCLES  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dbg_state;
  logic [3:0] dbg_starve_cnt;
  int         checks = 0;
  int         errors = 0;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // ---------------- memory environment ----------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8C22_0004;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  logic [31:0] mem [0:MEM_WORDS-1];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_strobes"}, 32'({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid,
                                 bus.if_err, bus.d_err, bus.mem_read, bus.mem_write}), 32'h0);
    chk({name, "_mem_addr"},  bus.mem_addr, 32'h0);
    chk({name, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({name, "_if_rdata"},  bus.if_rdata, 32'h0);
    chk({name, "_d_rdata"},   bus.d_rdata, 32'h0);
    chk({name, "_state"},     32'(dbg_state), 32'h0);
    chk({name, "_starve"},    32'(dbg_starve_cnt), 32'h0);
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(MEM_WORDS));
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
    if (sel == 0)      a = a | 32'($urandom_range(1, 3));
    else if (sel == 1) a = a + 32'h400;
    else if (sel == 2) a = a + 32'h3C0;
    return a;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rd;
    logic        exp_wr;
    logic        exp_rvalid;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [0:NVEC-1];
  logic exp_order [0:5];
  int   exp_cnt   [0:5];

  // ---------------- random-phase reference model ----------------
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];

  initial begin
    int          ngr, cyc, waited, losses;
    int unsigned eg, er, ng, nr;
    logic        if_pend, d_pend, t_d, t_we, ok;
    logic [31:0] t_addr, t_wdata, e;

    vecs[0] = '{is_d:1'b0, we:1'b0, addr:32'h10,  wdata:32'h0,         exp_rd:1'b1, exp_wr:1'b0, exp_rvalid:1'b1, exp_err:1'b0, exp_rdata:32'h8C22_0004};
    vecs[1] = '{is_d:1'b1, we:1'b1, addr:32'h40,  wdata:32'hDEAD_BEEF, exp_rd:1'b0, exp_wr:1'b1, exp_rvalid:1'b0, exp_err:1'b0, exp_rdata:32'h0};
    vecs[2] = '{is_d:1'b1, we:1'b0, addr:32'h40,  wdata:32'h0,         exp_rd:1'b1, exp_wr:1'b0, exp_rvalid:1'b1, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};
    vecs[3] = '{is_d:1'b1, we:1'b0, addr:32'h42,  wdata:32'h0,         exp_rd:1'b0, exp_wr:1'b0, exp_rvalid:1'b0, exp_err:1'b1, exp_rdata:32'hDEAD_BEEF};
    vecs[4] = '{is_d:1'b0, we:1'b0, addr:32'h400, wdata:32'h0,         exp_rd:1'b0, exp_wr:1'b0, exp_rvalid:1'b0, exp_err:1'b1, exp_rdata:32'h8C22_0004};
    vecs[5] = '{is_d:1'b1, we:1'b1, addr:32'h3FC, wdata:32'h1234_5678, exp_rd:1'b0, exp_wr:1'b1, exp_rvalid:1'b0, exp_err:1'b0, exp_rdata:32'hDEAD_BEEF};
    vecs[6] = '{is_d:1'b0, we:1'b0, addr:32'h3FC, wdata:32'h0,         exp_rd:1'b1, exp_wr:1'b0, exp_rvalid:1'b1, exp_err:1'b0, exp_rdata:32'h1234_5678};
    vecs[7] = '{is_d:1'b1, we:1'b1, addr:32'h401, wdata:32'hAAAA_5555, exp_rd:1'b0, exp_wr:1'b0, exp_rvalid:1'b0, exp_err:1'b1, exp_rdata:32'hDEAD_BEEF};
    vecs[8] = '{is_d:1'b0, we:1'b0, addr:32'h3FF, wdata:32'h0,         exp_rd:1'b0, exp_wr:1'b0, exp_rvalid:1'b0, exp_err:1'b1, exp_rdata:32'h1234_5678};

    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
    exp_order[3] = 1'b1; exp_order[4] = 1'b1; exp_order[5] = 1'b0;
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 0;
    exp_cnt[3] = 1; exp_cnt[4] = 2; exp_cnt[5] = 0;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0;  bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single transactions from IDLE
    for (int v = 0; v < NVEC; v++) begin
      if (vecs[v].is_d) begin
        bus.d_req = 1'b1; bus.d_we = vecs[v].we;
        bus.d_addr = vecs[v].addr; bus.d_wdata = vecs[v].wdata;
      end else begin
        bus.if_req = 1'b1; bus.if_addr = vecs[v].addr;
      end
      step();
      chk($sformatf("v%0d_if_gnt", v), 32'(bus.if_gnt), 32'(!vecs[v].is_d));
      chk($sformatf("v%0d_d_gnt", v), 32'(bus.d_gnt), 32'(vecs[v].is_d));
      chk($sformatf("v%0d_mem_read", v), 32'(bus.mem_read), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_mem_write", v), 32'(bus.mem_write), 32'(vecs[v].exp_wr));
      chk($sformatf("v%0d_mem_addr", v), bus.mem_addr, vecs[v].addr);
      chk($sformatf("v%0d_mem_wdata", v), bus.mem_wdata, vecs[v].is_d ? vecs[v].wdata : 32'h0);
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      step();
      chk($sformatf("v%0d_resp_mem", v), 32'({bus.mem_read, bus.mem_write, bus.if_gnt, bus.d_gnt}), 32'h0);
      if (vecs[v].is_d) begin
        chk($sformatf("v%0d_d_rvalid", v), 32'(bus.d_rvalid), 32'(vecs[v].exp_rvalid));
        chk($sformatf("v%0d_d_err", v), 32'(bus.d_err), 32'(vecs[v].exp_err));
        chk($sformatf("v%0d_if_quiet", v), 32'({bus.if_rvalid, bus.if_err}), 32'h0);
        chk($sformatf("v%0d_d_rdata", v), bus.d_rdata, vecs[v].exp_rdata);
      end else begin
        chk($sformatf("v%0d_if_rvalid", v), 32'(bus.if_rvalid), 32'(vecs[v].exp_rvalid));
        chk($sformatf("v%0d_if_err", v), 32'(bus.if_err), 32'(vecs[v].exp_err));
        chk($sformatf("v%0d_d_quiet", v), 32'({bus.d_rvalid, bus.d_err}), 32'h0);
        chk($sformatf("v%0d_if_rdata", v), bus.if_rdata, vecs[v].exp_rdata);
      end
    end

    // Back-to-back fetches: each rvalid lands in the cycle of the next arbitration
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (!bus.if_gnt && waited < 4) begin
        step();
        waited++;
      end
      chk($sformatf("b2b%0d_gap", k), 32'(waited), 32'd1);
      chk($sformatf("b2b%0d_addr", k), bus.mem_addr, 32'(k * 4));
      if (k < 2) bus.if_addr = 32'((k + 1) * 4);
      else       bus.if_req = 1'b0;
      step();
      chk($sformatf("b2b%0d_rvalid", k), 32'(bus.if_rvalid), 32'h1);
      chk($sformatf("b2b%0d_rdata", k), bus.if_rdata, init_word(k));
      chk($sformatf("b2b%0d_no_gnt", k), 32'(bus.if_gnt), 32'h0);
    end
    step();

    // Starvation guard with both requests held
    chk("starve_init", 32'(dbg_starve_cnt), 32'h0);
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h8;
    ngr = 0; cyc = 0;
    while (ngr < 6 && cyc < 20) begin
      step();
      cyc++;
      if (bus.if_gnt || bus.d_gnt) begin
        chk($sformatf("starve_owner%0d", ngr), 32'(bus.d_gnt), 32'(exp_order[ngr]));
        chk($sformatf("starve_cnt%0d", ngr), 32'(dbg_starve_cnt), 32'(exp_cnt[ngr]));
        ngr++;
      end
    end
    chk("starve_grants", 32'(ngr), 32'd6);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    step();
    step();

    // Reset in the middle of a write access
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFE_F00D;
    step();
    chk("rstmid_gnt_before", 32'(bus.d_gnt), 32'h1);
    chk("rstmid_wr_before", 32'(bus.mem_write), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_gnt_async", 32'(bus.d_gnt), 32'h0);
    chk("rstmid_wr_async", 32'(bus.mem_write), 32'h0);
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rstmid_word", mem[32], init_word(32));
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all_zero($sformatf("rstmid_after%0d", k));
    end

    // Random traffic against the transaction-level model
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    ref_mem[16]  = 32'hDEAD_BEEF;
    ref_mem[255] = 32'h1234_5678;
    eg = 0; er = 0; losses = 0;
    if_pend = 1'b0; d_pend = 1'b0;
    t_d = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    for (int c = 0; c < RAND_CYCLES + 12; c++) begin
      step();
      chk("rnd_if_gnt", 32'(bus.if_gnt), 32'(eg == 1));
      chk("rnd_d_gnt", 32'(bus.d_gnt), 32'(eg == 2));
      chk("rnd_state", 32'(dbg_state), 32'(eg != 0));
      chk("rnd_if_rvalid", 32'(bus.if_rvalid), 32'(er == 1));
      chk("rnd_if_err", 32'(bus.if_err), 32'(er == 2));
      chk("rnd_d_rvalid", 32'(bus.d_rvalid), 32'(er == 3));
      chk("rnd_d_err", 32'(bus.d_err), 32'(er == 4));
      chk("rnd_starve", 32'(dbg_starve_cnt), 32'(losses));
      if (er == 1) begin
        e = exp_if_q.pop_front();
        chk("rnd_if_rdata", bus.if_rdata, e);
      end
      if (er == 3) begin
        e = exp_d_q.pop_front();
        chk("rnd_d_rdata", bus.d_rdata, e);
      end
      if (eg != 0) begin
        ok = addr_ok(t_addr);
        chk("rnd_mem_addr", bus.mem_addr, t_addr);
        chk("rnd_mem_rw", 32'({bus.mem_read, bus.mem_write}), 32'({!t_we && ok, t_we && ok}));
        chk("rnd_mem_wdata", bus.mem_wdata, t_d ? t_wdata : 32'h0);
      end
      if (bus.if_gnt) begin if_pend = 1'b0; bus.if_req = 1'b0; end
      if (bus.d_gnt)  begin d_pend = 1'b0;  bus.d_req = 1'b0;  end

      // Outcome of the access happening in this cycle, if any
      nr = 0;
      if (eg != 0) begin
        ok = addr_ok(t_addr);
        if (!ok)        nr = t_d ? 4 : 2;
        else if (t_we)  ref_mem[t_addr[9:2]] = t_wdata;
        else begin
          nr = t_d ? 3 : 1;
          if (t_d) exp_d_q.push_back(ref_mem[t_addr[9:2]]);
          else     exp_if_q.push_back(ref_mem[t_addr[9:2]]);
        end
      end

      if (c < RAND_CYCLES) begin
        if (!if_pend && $urandom_range(0, 2) != 0) begin
          if_pend = 1'b1; bus.if_req = 1'b1; bus.if_addr = rand_addr();
        end
        if (!d_pend && $urandom_range(0, 2) != 0) begin
          d_pend = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
          bus.d_addr = rand_addr(); bus.d_wdata = $urandom();
        end
      end

      // Arbitration: D preferred unless IF has already lost STARVE_LIMIT contests in a row
      ng = 0;
      if (eg == 0 && (if_pend || d_pend)) begin
        if (d_pend && !(if_pend && losses == STARVE_LIMIT)) begin
          ng = 2; t_d = 1'b1; t_we = bus.d_we; t_addr = bus.d_addr; t_wdata = bus.d_wdata;
          if (if_pend && losses < STARVE_LIMIT) losses++;
        end else begin
          ng = 1; t_d = 1'b0; t_we = 1'b0; t_addr = bus.if_addr; t_wdata = 32'h0;
          losses = 0;
        end
      end
      eg = ng;
      er = nr;
    end
    chk("rnd_drain_if_q", 32'(exp_if_q.size()), 32'h0);
    chk("rnd_drain_d_q", 32'(exp_d_q.size()), 32'h0);
    chk("rnd_drain_pend", 32'({if_pend, d_pend}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the instruction-fetch (IF) port and the load/store (D) port.
- Arbitrates between them with fixed data priority plus a starvation guard for IF.
- Sequences each access into a registered ACCESS cycle that drives the memory's read/write/address/write-data inputs.
- Returns registered read data and flags misaligned or out-of-range accesses.

Parameters:
- MEM_WORDS, 256: memory depth in 32-bit words. A word index (addr[31:2]) >= MEM_WORDS is out of range.
- STARVE_LIMIT, 2: number of consecutive contested arbitrations IF may lose before it is forced to win. Range 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; held with if_addr stable until if_gnt
- if_addr  in  32  IF byte address
- if_gnt  out  1  one-cycle pulse: IF request accepted (ACCESS cycle)
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- if_err  out  1  one-cycle pulse instead of if_rvalid on a bad address
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  one-cycle pulse: D request accepted
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only)
- d_rdata  out  32  loaded word
- d_err  out  1  one-cycle pulse on a bad address (read or write)
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  32  to memory Address
- mem_wdata  out  32  to memory WriteData
- mem_rdata  in  32  from memory ReadData (combinational read)

Behaviour:
- Reset: async on rst_n low. State goes to IDLE; every output, latched address/data, owner flag and starvation counter go to 0, effective immediately.
- Reset mid-ACCESS aborts the access: mem_write drops at once, and no gnt/rvalid/err is issued after release.
- State machine has two states: IDLE and ACCESS.
- IDLE:
  - Sample if_req/d_req at the rising edge.
  - Neither asserted: stay in IDLE.
  - Only one asserted: that one wins.
  - Both asserted: D wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - The winner's addr (and we/wdata for D) is latched, the owner is recorded, and the next state is ACCESS.
- ACCESS (exactly 1 cycle), then always back to IDLE:
  - The owner's gnt is high.
  - mem_addr = latched address.
  - mem_wdata = latched wdata (0 for IF).
  - mem_read = ~we & ok.
  - mem_write = we & ok, where ok = (addr[1:0] == 0) && (addr[31:2] < MEM_WORDS).
  - The memory write commits at the edge ending ACCESS.
  - On a read with ok, mem_rdata is captured into the owner's rdata register at that edge.
- Response, in the cycle after ACCESS:
  - Read with ok: owner's rvalid = 1.
  - Not ok: owner's err = 1, rvalid = 0, rdata unchanged.
  - Write with ok: no response pulse; d_gnt alone signals completion.
- rdata registers hold their value until the next successful read by the same port.
- Outside ACCESS, mem_read = mem_write = 0; mem_addr/mem_wdata hold their last latched values.
- Latency: request sampled at edge N, gnt in cycle N+1, rvalid/err in cycle N+2. Peak throughput is one access every 2 cycles.
- A new arbitration may occur in the same IDLE cycle that carries the previous rvalid.
- Starvation counter (4-bit):
  - Increments when both request and D wins.
  - Clears to 0 whenever IF is granted.
  - Saturates at STARVE_LIMIT.
  - Unchanged on uncontested D grants.
- Requests are not sampled during ACCESS. A requester deasserting req before gnt (protocol violation) is not required to be handled.
- gnt, rvalid and err are never high for both ports in the same cycle.

Test Plan:
- Reset then single IF read of 0x10, where the memory word there is 0x8C220004 -> if_gnt in cycle 1 with mem_read=1 and mem_addr=0x10; if_rvalid in cycle 2 with if_rdata=0x8C220004; mem_write stays 0 throughout.
- D write of 0xDEADBEEF to 0x40, then D read of 0x40 -> mem_write=1 in the write's ACCESS cycle only, no d_rvalid for the write; the read returns d_rdata=0xDEADBEEF with d_rvalid.
- if_req and d_req held continuously with STARVE_LIMIT=2 -> grant order D, D, IF, D, D, IF; starve_cnt reads 0, 1, 2, 0.
- D read at 0x42 (misaligned) and IF read at 0x400 (index 256, out of range) -> mem_read=mem_write=0 in both ACCESS cycles; d_err and if_err each pulse once; no rvalid; rdata unchanged.
- D write in progress, rst_n low mid-ACCESS -> mem_write and d_gnt drop to 0 asynchronously; the target word is unchanged; after release, IDLE with all outputs 0.
- Back-to-back IF reads at 0x0, 0x4, 0x8 -> gnt pulses every 2nd cycle; each rvalid coincides with the next arbitration cycle and carries the correct word.
